// File: rtl/inv_sbox_seq.sv
// rtl/inv_sbox_seq.sv - sequential bitsliced inverse 5-bit S-box over a 320-bit state
// Processes COLS_PER_CYCLE bit-columns per clock in place, then publishes the result with a done pulse.
module inv_sbox_seq #(
  parameter int CWIDTH         = 320,
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CWIDTH-1:0] c_in,
  output logic [CWIDTH-1:0] c_out,
  output logic              busy,
  output logic              done
);

  localparam int NPASS = 64 / COLS_PER_CYCLE;
  localparam int CNTW  = $clog2(NPASS) + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NPASS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (CWIDTH != 320) begin : g_bad_cwidth
    $error("inv_sbox_seq: CWIDTH must be 320");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4 &&
      COLS_PER_CYCLE != 8 && COLS_PER_CYCLE != 16 && COLS_PER_CYCLE != 32 &&
      COLS_PER_CYCLE != 64) begin : g_bad_cols
    $error("inv_sbox_seq: COLS_PER_CYCLE must be a power of two from 1 to 64");
  end

  function automatic logic [4:0] inv_lut(input logic [4:0] v);
    case (v)
      5'd0:  inv_lut = 5'h14;  5'd1:  inv_lut = 5'h1A;
      5'd2:  inv_lut = 5'h07;  5'd3:  inv_lut = 5'h0D;
      5'd4:  inv_lut = 5'h00;  5'd5:  inv_lut = 5'h09;
      5'd6:  inv_lut = 5'h0E;  5'd7:  inv_lut = 5'h12;
      5'd8:  inv_lut = 5'h0A;  5'd9:  inv_lut = 5'h06;
      5'd10: inv_lut = 5'h1D;  5'd11: inv_lut = 5'h01;
      5'd12: inv_lut = 5'h19;  5'd13: inv_lut = 5'h15;
      5'd14: inv_lut = 5'h13;  5'd15: inv_lut = 5'h1E;
      5'd16: inv_lut = 5'h18;  5'd17: inv_lut = 5'h16;
      5'd18: inv_lut = 5'h0B;  5'd19: inv_lut = 5'h11;
      5'd20: inv_lut = 5'h03;  5'd21: inv_lut = 5'h05;
      5'd22: inv_lut = 5'h1C;  5'd23: inv_lut = 5'h1F;
      5'd24: inv_lut = 5'h17;  5'd25: inv_lut = 5'h1B;
      5'd26: inv_lut = 5'h04;  5'd27: inv_lut = 5'h08;
      5'd28: inv_lut = 5'h0F;  5'd29: inv_lut = 5'h0C;
      5'd30: inv_lut = 5'h10;  default: inv_lut = 5'h02;
    endcase
  endfunction

  logic [1:0]        state;
  logic [CNTW-1:0]   cnt;
  logic [CWIDTH-1:0] work;
  logic [CWIDTH-1:0] work_next;

  // Column j gathers bit j of each 64-bit word, x0 (lowest word) as the MSB.
  always_comb begin
    logic [8:0] base;
    logic [8:0] idx;
    logic [4:0] v;
    logic [4:0] r;
    work_next = work;
    base = 9'(cnt) * 9'(COLS_PER_CYCLE);
    idx  = '0;
    v    = '0;
    r    = '0;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      idx = base + 9'(i);
      v = {work[idx], work[idx + 9'd64], work[idx + 9'd128],
           work[idx + 9'd192], work[idx + 9'd256]};
      r = inv_lut(v);
      work_next[idx]          = r[4];
      work_next[idx + 9'd64]  = r[3];
      work_next[idx + 9'd128] = r[2];
      work_next[idx + 9'd192] = r[1];
      work_next[idx + 9'd256] = r[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      work  <= '0;
      c_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            work  <= c_in;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          // Result is published on entry to DONE so c_out and done line up in that cycle.
          if (cnt == LAST_CNT) begin
            c_out <= work_next;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_inv_sbox_seq.sv
// tb/tb_inv_sbox_seq.sv - self-checking bench for inv_sbox_seq
// Three builds (8, 1 and 64 columns per clock) share one stimulus and are each checked against a state model.
module tb_inv_sbox_seq;

  localparam int NI = 3;
  localparam logic [319:0] X2ONES   = {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};
  localparam logic [319:0] ZERO_INV = {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF};

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [319:0] c_in;
  logic [319:0] c_out [NI];
  logic         busy  [NI];
  logic         done  [NI];

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] inv_t [32];
  logic [4:0] fwd_t [32];

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] map_state(input logic [319:0] s, input bit inverse);
    logic [319:0] o;
    logic [4:0]   v;
    o = '0;
    for (int j = 0; j < 64; j++) begin
      v = {s[j], s[64+j], s[128+j], s[192+j], s[256+j]};
      v = inverse ? inv_t[v] : fwd_t[v];
      {o[j], o[64+j], o[128+j], o[192+j], o[256+j]} = v;
    end
    return o;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int C = (g == 0) ? 8 : ((g == 1) ? 1 : 64);
    localparam int N = 64 / C;

    inv_sbox_seq #(.CWIDTH(320), .COLS_PER_CYCLE(C)) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .c_in  (c_in),
      .c_out (c_out[g]),
      .busy  (busy[g]),
      .done  (done[g])
    );

    // t counts cycles since the accepted start: 1..N are RUN, N+1 is the done cycle, 0 is idle.
    int           t = 0;
    logic [319:0] exp_r = '0;
    logic [319:0] last_r = '0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        t = 0;
        last_r = '0;
      end else if (t == 0) begin
        if (start) begin
          t = 1;
          exp_r = map_state(c_in, 1'b1);
        end
      end else if (t == N + 1) begin
        t = 0;
      end else begin
        t = t + 1;
        if (t == N + 1) last_r = exp_r;
      end
    end

    always @(negedge clk) begin
      check($sformatf("busy[C=%0d]", C), 320'(busy[g]), 320'(t != 0));
      check($sformatf("done[C=%0d]", C), 320'(done[g]), 320'(t == N + 1));
      check($sformatf("c_out[C=%0d]", C), c_out[g], last_r);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy[0] || busy[1] || busy[2]) && k < 200) begin
      step();
      k++;
    end
    check("wait_idle_timeout", 320'(k < 200), 320'(1));
  endtask

  task automatic run_one(input logic [319:0] d, output logic [319:0] r);
    int k;
    k = 0;
    while (busy[0] && k < 50) begin
      step();
      k++;
    end
    start = 1'b1;
    c_in  = d;
    step();
    start = 1'b0;
    k = 0;
    while (!done[0] && k < 100) begin
      step();
      k++;
    end
    check("done_latency", 320'(k), 320'(8));
    r = c_out[0];
  endtask

  initial begin
    logic [319:0] r;
    logic [319:0] rs;
    int           ndone;

    inv_t = '{5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
              5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
              5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
              5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02};
    for (int v = 0; v < 32; v++) fwd_t[inv_t[v]] = 5'(v);

    reset = 1'b1;
    start = 1'b0;
    c_in  = '0;
    repeat (3) step();
    check("reset_busy", 320'(busy[0]), 320'(0));
    check("reset_cout", c_out[0], 320'(0));
    reset = 1'b0;

    check("pin_inv_x2", map_state(X2ONES, 1'b1), 320'(0));
    check("pin_inv_zero", map_state('0, 1'b1), ZERO_INV);
    check("pin_fwd_zero", map_state('0, 1'b0), X2ONES);

    wait_idle();
    run_one(X2ONES, r);
    check("x2_ones", r, 320'(0));
    wait_idle();
    run_one('0, r);
    check("all_zero", r, ZERO_INV);
    wait_idle();

    for (int i = 0; i < 100; i++) begin
      rs = rand_state();
      run_one(map_state(rs, 1'b0), r);
      check($sformatf("roundtrip_%0d", i), r, rs);
    end

    wait_idle();
    start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      c_in = rand_state();
      step();
      if (done[0]) ndone++;
    end
    start = 1'b0;
    check("held_start_dones", 320'(ndone), 320'(5));

    wait_idle();
    start = 1'b1;
    c_in  = rand_state();
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("midrun_reset_busy", 320'(busy[0]), 320'(0));
    check("midrun_reset_cout", c_out[0], 320'(0));
    step();
    reset = 1'b0;
    check("midrun_reset_done", 320'(done[0]), 320'(0));
    run_one(map_state(320'(1), 1'b0), r);
    check("after_reset_one", r, 320'(1));

    wait_idle();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
